// File: rtl/symmetric_matrix_unpacker_if.sv
// Handshake bundle between the packed upper-triangular source, the unpacker
// and the full-matrix consumer.
interface symmetric_matrix_unpacker_if #(
    parameter int N      = 4,
    parameter int DATA_W = 32
);
    localparam int RW = ($clog2(N) > 1) ? $clog2(N) : 1;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [RW-1:0]     out_row;
    logic [RW-1:0]     out_col;
    logic              out_last;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_row, out_col, out_last
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_row, out_col, out_last
    );
endinterface

// File: rtl/symmetric_matrix_unpacker.sv
// Buffers a packed upper-triangular symmetric matrix, then replays the full
// N x N matrix row-major, mirroring the lower triangle from the stored words.
module symmetric_matrix_unpacker #(
    parameter int N      = 4,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    symmetric_matrix_unpacker_if.slave bus,
    output logic                       busy,
    output logic                       err
);
    localparam int T  = N * (N + 1) / 2;
    localparam int RW = ($clog2(N) > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(T + 1);
    localparam int AW = $clog2(T);

    localparam logic [CW-1:0] LAST_WR = CW'(T - 1);
    localparam logic [RW-1:0] LAST_RC = RW'(N - 1);

    typedef enum logic [0:0] {
        ST_LOAD,
        ST_EMIT
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   wr_cnt_reg, wr_cnt_next;
    logic [RW-1:0]   row_reg, row_next;
    logic [RW-1:0]   col_reg, col_next;
    logic            err_reg, err_next;
    logic            wr_en;
    logic            in_fire;
    logic            out_fire;

    logic [DATA_W-1:0] buf_mem [T];

    // Packed offset of the first stored word of each row: r*N - r*(r-1)/2.
    logic [AW-1:0] row_base [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_row_base
            localparam int BASE = gi * N - (gi * (gi - 1)) / 2;
            assign row_base[gi] = BASE[AW-1:0];
        end
    endgenerate

    // Lower-triangle elements read their mirrored upper-triangle word.
    logic [RW-1:0] lo_idx;
    logic [RW-1:0] hi_idx;
    logic [AW-1:0] rd_idx;

    always_comb begin
        lo_idx = row_reg;
        hi_idx = col_reg;
        if (col_reg < row_reg) begin
            lo_idx = col_reg;
            hi_idx = row_reg;
        end
    end

    // Modular arithmetic at AW bits is exact because the final index is < T.
    assign rd_idx = row_base[lo_idx] + AW'(hi_idx) - AW'(lo_idx);

    assign bus.in_ready  = (state_reg == ST_LOAD);
    assign bus.out_valid = (state_reg == ST_EMIT);
    assign bus.out_data  = buf_mem[rd_idx];
    assign bus.out_row   = row_reg;
    assign bus.out_col   = col_reg;
    assign bus.out_last  = (state_reg == ST_EMIT) && (row_reg == LAST_RC) && (col_reg == LAST_RC);
    assign busy          = (state_reg == ST_EMIT);
    assign err           = err_reg;

    assign in_fire  = bus.in_valid && bus.in_ready;
    assign out_fire = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= ST_LOAD;
            wr_cnt_reg <= '0;
            row_reg    <= '0;
            col_reg    <= '0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            wr_cnt_reg <= wr_cnt_next;
            row_reg    <= row_next;
            col_reg    <= col_next;
            err_reg    <= err_next;
        end
    end

    // Storage is deliberately not reset; a new load overwrites every word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_mem[wr_cnt_reg] <= bus.in_data;
        end
    end

    always_comb begin
        state_next  = state_reg;
        wr_cnt_next = wr_cnt_reg;
        row_next    = row_reg;
        col_next    = col_reg;
        err_next    = err_reg;
        wr_en       = 1'b0;

        case (state_reg)
            ST_LOAD: begin
                if (in_fire) begin
                    wr_en = 1'b1;
                    if (wr_cnt_reg == LAST_WR) begin
                        wr_cnt_next = '0;
                        row_next    = '0;
                        col_next    = '0;
                        state_next  = ST_EMIT;
                        if (!bus.in_last) begin
                            err_next = 1'b1;
                        end
                    end else begin
                        wr_cnt_next = wr_cnt_reg + CW'(1);
                        if (bus.in_last) begin
                            err_next = 1'b1;
                        end
                    end
                end
            end

            ST_EMIT: begin
                if (out_fire) begin
                    if (col_reg == LAST_RC) begin
                        col_next = '0;
                        if (row_reg == LAST_RC) begin
                            row_next   = '0;
                            state_next = ST_LOAD;
                        end else begin
                            row_next = row_reg + RW'(1);
                        end
                    end else begin
                        col_next = col_reg + RW'(1);
                    end
                end
            end

            default: begin
                state_next = ST_LOAD;
            end
        endcase
    end
endmodule

// File: tb/tb_symmetric_matrix_unpacker.sv
// Directed bench for symmetric_matrix_unpacker: scoreboard of expected full
// matrices, monitor on the falling edge, stimulus on the rising edge + 1.
module tb_symmetric_matrix_unpacker;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int T  = N * (N + 1) / 2;
    localparam int RW = 2;

    typedef struct {
        logic [DW-1:0] data;
        logic [RW-1:0] row;
        logic [RW-1:0] col;
        logic          last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    logic err;

    always #5 clk = ~clk;

    symmetric_matrix_unpacker_if #(.N(N), .DATA_W(DW)) bus ();

    symmetric_matrix_unpacker #(.N(N), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .busy  (busy),
        .err   (err)
    );

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   n_out = 0;
    int   last_xfer_cyc = -1;
    int   first_acc = -1;
    bit   mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv)
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic timeout_fail(input string tag);
        tests++;
        fails++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    // Monitor: checks stall stability and pops the scoreboard on each transfer.
    initial begin : monitor
        exp_t held;
        exp_t e;
        bit   stall_prev;
        stall_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("hold_valid", 64'(bus.out_valid), 64'(1));
                    check("hold_data",  64'(bus.out_data),  64'(held.data));
                    check("hold_row",   64'(bus.out_row),   64'(held.row));
                    check("hold_col",   64'(bus.out_col),   64'(held.col));
                    check("hold_last",  64'(bus.out_last),  64'(held.last));
                end
                if (bus.out_valid) begin
                    check("in_ready_low_in_emit", 64'(bus.in_ready), 64'(0));
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $error("FAIL extra_out observed=0x%0h expected=none", bus.out_data);
                    end else begin
                        e = sb.pop_front();
                        check("out_data", 64'(bus.out_data), 64'(e.data));
                        check("out_row",  64'(bus.out_row),  64'(e.row));
                        check("out_col",  64'(bus.out_col),  64'(e.col));
                        check("out_last", 64'(bus.out_last), 64'(e.last));
                        $display("[TB] out (%0d,%0d) data=%0d last=%0b", bus.out_row, bus.out_col,
                                 bus.out_data, bus.out_last);
                    end
                    n_out++;
                    if (bus.out_last) last_xfer_cyc = cyc + 1;
                end
                stall_prev = bus.out_valid && !bus.out_ready;
                held.data  = bus.out_data;
                held.row   = bus.out_row;
                held.col   = bus.out_col;
                held.last  = bus.out_last;
            end
        end
    end

    // Push the full mirrored matrix built by walking the packed stream.
    task automatic push_expected(input int base);
        logic [DW-1:0] m [N][N];
        exp_t e;
        int k;
        k = 0;
        for (int r = 0; r < N; r++) begin
            for (int c = r; c < N; c++) begin
                m[r][c] = DW'(base + k);
                m[c][r] = DW'(base + k);
                k++;
            end
        end
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                e.data = m[r][c];
                e.row  = RW'(r);
                e.col  = RW'(c);
                e.last = (r == N - 1) && (c == N - 1);
                sb.push_back(e);
            end
        end
    endtask

    // Loads words base..base+T-1; bad_pos >= 0 puts in_last there instead of on the final word.
    task automatic load(input int base, input int bad_pos, input bit hold_valid);
        int w;
        for (int k = 0; k < T; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = DW'(base + k);
            bus.in_last  = (bad_pos >= 0) ? (k == bad_pos) : (k == T - 1);
            w = 0;
            @(negedge clk);
            while (!bus.in_ready && w < 200) begin
                @(negedge clk);
                w++;
            end
            if (w >= 200) timeout_fail("load_wait_ready");
            if (k == 0) first_acc = cyc + 1;
            @(posedge clk);
            #1;
            $display("[TB] in word %0d data=%0d last=%0b", k, base + k, bus.in_last);
            if (bad_pos >= 0 && k == bad_pos) check("err_after_bad_last", 64'(err), 64'(1));
        end
        if (!hold_valid) begin
            bus.in_valid = 1'b0;
            bus.in_last  = 1'b0;
        end
        push_expected(base);
    endtask

    task automatic drain(input bit rnd);
        int w;
        w = 0;
        while ((sb.size() != 0 || bus.out_valid) && w < 300) begin
            bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk);
            #1;
            w++;
        end
        bus.out_ready = 1'b1;
        if (w >= 300) timeout_fail("drain");
        check("drained_out_valid", 64'(bus.out_valid), 64'(0));
        check("drained_in_ready",  64'(bus.in_ready),  64'(1));
        check("drained_busy",      64'(busy),          64'(0));
    endtask

    initial begin : stimulus
        int w;
        int n0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_in_ready",  64'(bus.in_ready),  64'(1));
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_out_last",  64'(bus.out_last),  64'(0));
        check("rst_busy",      64'(busy),          64'(0));
        check("rst_err",       64'(err),           64'(0));
        check("rst_row",       64'(bus.out_row),   64'(0));
        check("rst_col",       64'(bus.out_col),   64'(0));
        mon_en = 1'b1;

        // 1: basic load and full-rate replay
        load(1, -1, 1'b0);
        check("t1_busy", 64'(busy), 64'(1));
        check("t1_valid_next_cycle", 64'(bus.out_valid), 64'(1));
        drain(1'b0);
        check("t1_err", 64'(err), 64'(0));

        // 2: random backpressure
        load(1, -1, 1'b0);
        drain(1'b1);

        // 3: input offered during EMIT must be ignored
        load(1, -1, 1'b0);
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'hDEAD;
        bus.in_last   = 1'b1;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        drain(1'b0);
        check("t3_err", 64'(err), 64'(0));

        // 4: early in_last sets sticky err; framing by count only
        load(101, 4, 1'b0);
        drain(1'b0);
        load(201, -1, 1'b0);
        drain(1'b0);
        check("t4_err_sticky", 64'(err), 64'(1));

        // 5: reset while element 7 is presented
        load(1, -1, 1'b0);
        n0 = n_out;
        w = 0;
        while (n_out < n0 + 6 && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (w >= 100) timeout_fail("t5_wait_elem7");
        check("t5_pre_row", 64'(bus.out_row), 64'(1));
        check("t5_pre_col", 64'(bus.out_col), 64'(2));
        mon_en = 1'b0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("t5_out_valid", 64'(bus.out_valid), 64'(0));
        check("t5_in_ready",  64'(bus.in_ready),  64'(1));
        check("t5_err",       64'(err),           64'(0));
        check("t5_busy",      64'(busy),          64'(0));
        sb.delete();
        bus.out_ready = 1'b1;
        mon_en = 1'b1;
        load(11, -1, 1'b0);
        drain(1'b0);

        // 6: back-to-back with in_valid held high
        load(21, -1, 1'b1);
        load(41, -1, 1'b0);
        check("t6_first_accept_cycle", 64'(first_acc), 64'(last_xfer_cyc + 1));
        drain(1'b0);
        check("t6_err", 64'(err), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
